imm_gen_pipe: RTL

- Parametrised, pipelined immediate generator for the decode stage.
- Takes `instr[31:7]` plus an immediate-format select and produces a sign- or zero-extended immediate of width XLEN.
- Result is registered in a 2-entry valid/ready skid buffer with a sideband tag (PC or ROB index).
- Beyond the base I/S/B/J/U formats it adds CSR zero-immediate, shift-amount and illegal-format detection, plus a synchronous flush for branch redirects.

---
 rtl/imm_gen_pipe.sv | 121 ++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator.
// The instruction's immediate field is decoded combinationally and then held in
// a two-entry valid/ready skid buffer (main output register + one overflow
// entry). A sideband tag travels alongside each immediate.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_instr,   // instr[31:7]; bit k of instr is in_instr[k-7]
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t           r_state, w_state_nxt;
  logic [XLEN-1:0]  w_imm, r_imm, r_sk_imm;
  logic [TAG_W-1:0] r_tag, r_sk_tag;
  logic             w_ill, r_ill, r_sk_ill;
  logic             w_acc, w_fire;
  logic             w_ld_main, w_ld_skid, w_sk_to_main;

  // Format decode: signed casts give sign extension, plain casts zero extension.
  always_comb begin
    w_imm = '0;
    w_ill = 1'b0;
    case (in_immsrc)
      3'b000: w_imm = XLEN'($signed(in_instr[24:13]));
      3'b001: w_imm = XLEN'($signed({in_instr[24:18], in_instr[4:0]}));
      3'b010: w_imm = XLEN'($signed({in_instr[24], in_instr[0], in_instr[23:18],
                                      in_instr[4:1], 1'b0}));
      3'b011: w_imm = XLEN'($signed({in_instr[24], in_instr[12:5], in_instr[13],
                                      in_instr[23:14], 1'b0}));
      3'b100: w_imm = XLEN'($signed({in_instr[24:5], 12'h000}));
      3'b101: w_imm = XLEN'(in_instr[12:8]);
      3'b110: w_imm = (XLEN == 64) ? XLEN'(in_instr[18:13]) : XLEN'(in_instr[17:13]);
      default: begin
        w_imm = '0;
        w_ill = 1'b1;
      end
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next occupancy; flush overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_acc) w_state_nxt = S_ONE;
        S_ONE: begin
          if (w_acc && !w_fire)      w_state_nxt = S_FULL;
          else if (!w_acc && w_fire) w_state_nxt = S_EMPTY;
        end
        S_FULL:  if (w_fire) w_state_nxt = S_ONE;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Handshake outputs and datapath load enables, all derived from the state register
  // so in_ready never sees out_ready combinationally.
  always_comb begin
    out_valid    = (r_state != S_EMPTY);
    in_ready     = (r_state != S_FULL);
    w_acc        = in_valid && in_ready && !flush;
    w_fire       = out_valid && out_ready;
    w_ld_main    = w_acc && ((r_state == S_EMPTY) || ((r_state == S_ONE) && w_fire));
    w_ld_skid    = w_acc && (r_state == S_ONE) && !w_fire;
    w_sk_to_main = !flush && (r_state == S_FULL) && w_fire;
  end

  // Data registers only move on accept or on skid-to-main promotion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imm    <= '0;
      r_tag    <= '0;
      r_ill    <= 1'b0;
      r_sk_imm <= '0;
      r_sk_tag <= '0;
      r_sk_ill <= 1'b0;
    end else begin
      if (w_ld_main) begin
        r_imm <= w_imm;
        r_tag <= in_tag;
        r_ill <= w_ill;
      end else if (w_sk_to_main) begin
        r_imm <= r_sk_imm;
        r_tag <= r_sk_tag;
        r_ill <= r_sk_ill;
      end
      if (w_ld_skid) begin
        r_sk_imm <= w_imm;
        r_sk_tag <= in_tag;
        r_sk_ill <= w_ill;
      end
    end
  end

  assign out_imm     = r_imm;
  assign out_tag     = r_tag;
  assign out_illegal = r_ill;

endmodule
